// File: rtl/decode_if.sv
// -----------------------------------------------------------------------------
// decode_if
// Purpose : bundles the fetch-side handshake, the control inputs and the
//           decoded execute-side bundle of the decode stage into one interface.
// Params  : RA_W   register-address width (instruction width = 3*RA_W+7)
//           DATA_W datapath width of the sign-extended imm/off fields
// Signals : in_valid/in_ready/inst  fetch handshake and instruction word
//           flush, resume           pipeline control
//           out_valid/out_ready     execute handshake
//           dr,sa,sb,imm,off,mb,md,ld,mw,fs,bs  decoded bundle
//           halted, illegal         status
// Modports: master = fetch/execute environment, slave = decode stage
// -----------------------------------------------------------------------------
interface decode_if #(
  parameter int RA_W   = 3,
  parameter int DATA_W = 16
);
  localparam int INST_W = 3*RA_W + 7;

  logic              in_valid;
  logic              in_ready;
  logic [INST_W-1:0] inst;
  logic              flush;
  logic              resume;
  logic              out_valid;
  logic              out_ready;
  logic [RA_W-1:0]   dr;
  logic [RA_W-1:0]   sa;
  logic [RA_W-1:0]   sb;
  logic [DATA_W-1:0] imm;
  logic [DATA_W-1:0] off;
  logic              mb;
  logic              md;
  logic              ld;
  logic              mw;
  logic [2:0]        fs;
  logic [2:0]        bs;
  logic              halted;
  logic              illegal;

  modport master (
    output in_valid, inst, flush, resume, out_ready,
    input  in_ready, out_valid, dr, sa, sb, imm, off, mb, md, ld, mw, fs, bs,
           halted, illegal
  );

  modport slave (
    input  in_valid, inst, flush, resume, out_ready,
    output in_ready, out_valid, dr, sa, sb, imm, off, mb, md, ld, mw, fs, bs,
           halted, illegal
  );
endinterface

// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
// Purpose : registered instruction-decode stage between fetch and execute for
//           the 4-bit-opcode ISA. Adds valid/ready handshake, load-use
//           interlock, HALT/RESUME state machine and flush.
// Ports   : clk    rising-edge clock
//           rst_n  asynchronous active-low reset
//           bus    decode_if.slave (fetch handshake, flush/resume, decoded
//                  bundle, halted/illegal status)
// Config  : ILLEGAL_OP_EN - when defined, undefined opcodes capture a NOP
//           bundle, pulse illegal for one cycle and enter HALT. When not
//           defined they decode as NOP and illegal is tied 0.
// -----------------------------------------------------------------------------
module decode_stage #(
  parameter int RA_W   = 3,
  parameter int DATA_W = 16
) (
  input  logic     clk,
  input  logic     rst_n,
  decode_if.slave  bus
);
  localparam int INST_W = 3*RA_W + 7;
  localparam int IMM_W  = RA_W + 3;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_LD   = 4'b0010;
  localparam logic [3:0] OP_ST   = 4'b0100;
  localparam logic [3:0] OP_ADDI = 4'b0101;
  localparam logic [3:0] OP_ANDI = 4'b0110;
  localparam logic [3:0] OP_ORI  = 4'b0111;
  localparam logic [3:0] OP_B0   = 4'b1000;
  localparam logic [3:0] OP_B1   = 4'b1001;
  localparam logic [3:0] OP_B2   = 4'b1010;
  localparam logic [3:0] OP_B3   = 4'b1011;
  localparam logic [3:0] OP_R    = 4'b1111;
  localparam logic [2:0] BS_NONE = 3'b100;

  typedef struct packed {
    logic [RA_W-1:0]   dr;
    logic [RA_W-1:0]   sa;
    logic [RA_W-1:0]   sb;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] off;
    logic              mb;
    logic              md;
    logic              ld;
    logic              mw;
    logic [2:0]        fs;
    logic [2:0]        bs;
  } bundle_t;

  typedef enum logic {ST_RUN = 1'b0, ST_HALT = 1'b1} state_e;

  // instruction fields: {op, rs, rt, rd, funct}; imm/offset = {rd, funct}
  logic [3:0]        op_s;
  logic [RA_W-1:0]   rs_s;
  logic [RA_W-1:0]   rt_s;
  logic [RA_W-1:0]   rd_s;
  logic [2:0]        funct_s;
  logic [IMM_W-1:0]  immf_s;
  logic [DATA_W-1:0] sext_s;

  assign op_s    = bus.inst[INST_W-1 -: 4];
  assign rs_s    = bus.inst[INST_W-5 -: RA_W];
  assign rt_s    = bus.inst[INST_W-5-RA_W -: RA_W];
  assign rd_s    = bus.inst[RA_W+2 -: RA_W];
  assign funct_s = bus.inst[2:0];
  assign immf_s  = bus.inst[IMM_W-1:0];
  assign sext_s  = {{(DATA_W-IMM_W){immf_s[IMM_W-1]}}, immf_s};

  bundle_t dec_s;
  logic    use_a_s;
  logic    use_b_s;
  logic    halt_req_s;
`ifdef ILLEGAL_OP_EN
  logic    illegal_op_s;
`endif

  // combinational decode of the presented instruction
  always_comb begin
    dec_s      = '0;
    dec_s.bs   = BS_NONE;
    use_a_s    = 1'b0;
    use_b_s    = 1'b0;
    halt_req_s = 1'b0;
`ifdef ILLEGAL_OP_EN
    illegal_op_s = 1'b0;
`endif
    case (op_s)
      OP_NOP: begin
        dec_s.fs   = funct_s;
        halt_req_s = (funct_s != 3'b000);
      end
      OP_LD: begin
        dec_s.dr = rt_s; dec_s.sa = rs_s; dec_s.imm = sext_s;
        dec_s.mb = 1'b1; dec_s.md = 1'b1; dec_s.ld = 1'b1;
        use_a_s  = 1'b1;
      end
      OP_ST: begin
        dec_s.sa = rs_s; dec_s.sb = rt_s; dec_s.imm = sext_s;
        dec_s.mb = 1'b1; dec_s.mw = 1'b1;
        use_a_s  = 1'b1; use_b_s = 1'b1;
      end
      OP_ADDI, OP_ANDI, OP_ORI: begin
        dec_s.dr = rt_s; dec_s.sa = rs_s; dec_s.imm = sext_s;
        dec_s.mb = 1'b1; dec_s.ld = 1'b1;
        dec_s.fs = (op_s == OP_ADDI) ? 3'b000 : ((op_s == OP_ANDI) ? 3'b101 : 3'b110);
        use_a_s  = 1'b1;
      end
      OP_R: begin
        dec_s.dr = rd_s; dec_s.sa = rs_s; dec_s.sb = rt_s;
        dec_s.fs = funct_s; dec_s.ld = 1'b1;
        use_a_s  = 1'b1; use_b_s = 1'b1;
      end
      OP_B0, OP_B1: begin
        dec_s.sa  = rs_s; dec_s.sb = rt_s; dec_s.fs = 3'b001;
        dec_s.bs  = (op_s == OP_B0) ? 3'b000 : 3'b001;
        dec_s.off = sext_s;
        use_a_s   = 1'b1; use_b_s = 1'b1;
      end
      OP_B2, OP_B3: begin
        dec_s.sa  = rs_s; dec_s.fs = 3'b010;
        dec_s.bs  = (op_s == OP_B2) ? 3'b010 : 3'b011;
        dec_s.off = sext_s;
        use_a_s   = 1'b1;
      end
      4'b0001, 4'b0011, 4'b1100, 4'b1101, 4'b1110: begin
`ifdef ILLEGAL_OP_EN
        illegal_op_s = 1'b1;
        halt_req_s   = 1'b1;
`else
        halt_req_s   = 1'b0;
`endif
      end
      default: dec_s.bs = BS_NONE;
    endcase
  end

  state_e  state_q, state_d;
  bundle_t bundle_q, bundle_d;
  logic    out_valid_q, out_valid_d;
  logic    ld_bub_q, ld_bub_d;
  logic    in_ready_s, halted_s, capture_s;
  logic    hit_s, hazard_s;

  // ld_bub is only ever set in the cycle right after a load was captured, so
  // the output register still holds that load and its dr is bundle_q.dr.
  assign hit_s     = (use_a_s && (rs_s == bundle_q.dr)) || (use_b_s && (rt_s == bundle_q.dr));
  assign hazard_s  = hit_s && ((out_valid_q && bundle_q.md) || ld_bub_q);
  assign capture_s = bus.in_valid && in_ready_s;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: flush always wins, resume only matters in HALT
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (bus.flush)                    state_d = ST_RUN;
        else if (capture_s && halt_req_s) state_d = ST_HALT;
        else                              state_d = ST_RUN;
      end
      ST_HALT: begin
        if (bus.flush || bus.resume) state_d = ST_RUN;
        else                         state_d = ST_HALT;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // FSM outputs: acceptance and halt status
  always_comb begin
    halted_s   = (state_q == ST_HALT);
    in_ready_s = (state_q == ST_RUN) && !bus.flush && !hazard_s &&
                 (!out_valid_q || bus.out_ready);
  end

  // output-register next state; fields change only on capture
  always_comb begin
    bundle_d    = bundle_q;
    out_valid_d = out_valid_q;
    ld_bub_d    = 1'b0;
    if (bus.flush) begin
      out_valid_d = 1'b0;
    end else if (capture_s) begin
      out_valid_d = 1'b1;
      bundle_d    = dec_s;
      ld_bub_d    = dec_s.md;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // output bundle and interlock registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bundle_q    <= '{bs: BS_NONE, default: '0};
      out_valid_q <= 1'b0;
      ld_bub_q    <= 1'b0;
    end else begin
      bundle_q    <= bundle_d;
      out_valid_q <= out_valid_d;
      ld_bub_q    <= ld_bub_d;
    end
  end

`ifdef ILLEGAL_OP_EN
  logic illegal_q, illegal_d;
  assign illegal_d = capture_s && illegal_op_s;

  // one-cycle pulse accompanying a captured undefined opcode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= illegal_d;
    end
  end
  assign bus.illegal = illegal_q;
`else
  assign bus.illegal = 1'b0;
`endif

  assign bus.in_ready  = in_ready_s;
  assign bus.halted    = halted_s;
  assign bus.out_valid = out_valid_q;
  assign bus.dr        = bundle_q.dr;
  assign bus.sa        = bundle_q.sa;
  assign bus.sb        = bundle_q.sb;
  assign bus.imm       = bundle_q.imm;
  assign bus.off       = bundle_q.off;
  assign bus.mb        = bundle_q.mb;
  assign bus.md        = bundle_q.md;
  assign bus.ld        = bundle_q.ld;
  assign bus.mw        = bundle_q.mw;
  assign bus.fs        = bundle_q.fs;
  assign bus.bs        = bundle_q.bs;
endmodule
